// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO. It runs one radix-2 step per
// cycle on operand magnitudes, then applies a single sign-fix cycle before writing HI/LO.
module muldiv_sequencer #(
  parameter int NB_REG = 32,
  parameter int NB_OP  = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_start,
  input  logic [NB_OP-1:0]  i_op,
  input  logic [NB_REG-1:0] i_a,
  input  logic [NB_REG-1:0] i_b,
  input  logic              i_mthi,
  input  logic              i_mtlo,
  input  logic              i_mf,
  input  logic              i_flush,
  output logic [NB_REG-1:0] o_hi,
  output logic [NB_REG-1:0] o_lo,
  output logic              o_busy,
  output logic              o_stall,
  output logic              o_done,
  output logic              o_div_by_zero
);
  localparam int NB_CNT = $clog2(NB_REG) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_next;

  logic [NB_CNT-1:0] cnt;
  logic [NB_REG-1:0] opnd, acc_hi, acc_lo;
  logic              is_div, neg_res, neg_rem;

  logic              accept, op_div, op_sgn, a_neg, b_neg, dbz, run_last;
  logic [NB_REG-1:0] a_mag, b_mag;
  logic [NB_REG:0]   mul_sum, div_shift, div_diff;
  logic [2*NB_REG-1:0] prod_fix;
  logic [NB_REG-1:0] quo_fix, rem_fix;

  // flush in IDLE only suppresses a simultaneous start
  assign accept   = (state == IDLE) && i_valid && i_start && !i_flush;
  assign op_div   = i_op[1];
  assign op_sgn   = ~i_op[0];
  assign a_neg    = op_sgn & i_a[NB_REG-1];
  assign b_neg    = op_sgn & i_b[NB_REG-1];
  assign a_mag    = a_neg ? -i_a : i_a;
  assign b_mag    = b_neg ? -i_b : i_b;
  assign dbz      = accept & op_div & (i_b == '0);
  assign run_last = (cnt == NB_CNT'(NB_REG - 1));

  assign o_stall  = o_busy & (i_mf | i_start | i_mthi | i_mtlo);

  // multiply: shift-add with {acc_hi,acc_lo} as the product/multiplier register
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  // divide: restoring; acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in
  assign div_shift = {acc_hi, acc_lo[NB_REG-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  assign prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix  = neg_res ? -acc_lo : acc_lo;
  assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !dbz) state_next = RUN;
      RUN:     if (i_flush) state_next = IDLE;
               else if (run_last) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt           <= '0;
      opnd          <= '0;
      acc_hi        <= '0;
      acc_lo        <= '0;
      is_div        <= 1'b0;
      neg_res       <= 1'b0;
      neg_rem       <= 1'b0;
      o_hi          <= '0;
      o_lo          <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_div_by_zero <= 1'b0;
    end else begin
      o_done        <= 1'b0;
      o_div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (dbz) begin
            o_hi          <= i_a;
            o_lo          <= '1;
            o_done        <= 1'b1;
            o_div_by_zero <= 1'b1;
          end else if (accept) begin
            cnt     <= '0;
            is_div  <= op_div;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            acc_hi  <= '0;
            opnd    <= op_div ? b_mag : a_mag;
            acc_lo  <= op_div ? a_mag : b_mag;
            o_busy  <= 1'b1;
          end else if (i_valid && !i_start) begin
            if (i_mthi) o_hi <= i_a;
            if (i_mtlo) o_lo <= i_a;
          end
        end
        RUN: begin
          if (i_flush) o_busy <= 1'b0;
          cnt <= cnt + NB_CNT'(1);
          if (is_div) begin
            if (!div_diff[NB_REG]) begin
              acc_hi <= div_diff[NB_REG-1:0];
              acc_lo <= {acc_lo[NB_REG-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[NB_REG-1:0];
              acc_lo <= {acc_lo[NB_REG-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[NB_REG:1];
            acc_lo <= {mul_sum[0], acc_lo[NB_REG-1:1]};
          end
        end
        FIX: begin
          o_busy <= 1'b0;
          if (!i_flush) begin
            o_done <= 1'b1;
            if (is_div) begin
              o_hi <= rem_fix;
              o_lo <= quo_fix;
            end else begin
              o_hi <= prod_fix[2*NB_REG-1:NB_REG];
              o_lo <= prod_fix[NB_REG-1:0];
            end
          end
        end
        default: o_busy <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus queues expected HI/LO/div-by-zero,
// a negedge monitor pops and compares on every o_done pulse.
module tb_muldiv_sequencer;
  logic        i_clock, i_reset, i_valid, i_start, i_mthi, i_mtlo, i_mf, i_flush;
  logic [1:0]  i_op;
  logic [31:0] i_a, i_b, o_hi, o_lo;
  logic        o_busy, o_stall, o_done, o_div_by_zero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  muldiv_sequencer #(.NB_REG(32), .NB_OP(2)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_start(i_start),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_mthi(i_mthi), .i_mtlo(i_mtlo),
    .i_mf(i_mf), .i_flush(i_flush), .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy),
    .o_stall(o_stall), .o_done(o_done), .o_div_by_zero(o_div_by_zero)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest queued expectation
  always @(negedge i_clock) begin
    if (o_done) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got hi=%0h lo=%0h want no done", o_hi, o_lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (o_hi !== e.hi || o_lo !== e.lo || o_div_by_zero !== e.dbz) begin
          bad++;
          $display("FAIL result: got hi=%0h lo=%0h dbz=%0b want hi=%0h lo=%0h dbz=%0b",
                   o_hi, o_lo, o_div_by_zero, e.hi, e.lo, e.dbz);
        end
      end
    end
  end

  task automatic wait_done(output int busy_cnt, output bit seen);
    busy_cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge i_clock);
      if (o_busy) busy_cnt++;
      if (o_done) seen = 1'b1;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                        input int ebusy);
    int bc;
    bit seen;
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dbz = edbz;
    sb.push_back(e);
    i_valid = 1'b1; i_start = 1'b1; i_op = op; i_a = a; i_b = b;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    wait_done(bc, seen);
    check("done_seen", 64'(seen), 64'd1);
    check("busy_cycles", 64'(bc), 64'(ebusy));
  endtask

  task automatic mt(input bit hi, input logic [31:0] v);
    i_valid = 1'b1; i_a = v;
    if (hi) i_mthi = 1'b1; else i_mtlo = 1'b1;
    @(posedge i_clock); #1;
    i_mthi = 1'b0; i_mtlo = 1'b0;
  endtask

  initial begin
    int  bc;
    bit  seen;
    exp_t e;
    i_reset = 1'b1; i_valid = 1'b0; i_start = 1'b0; i_mthi = 1'b0; i_mtlo = 1'b0;
    i_mf = 1'b0; i_flush = 1'b0; i_op = 2'b00; i_a = '0; i_b = '0;
    #3;
    check("rst_hi", 64'(o_hi), 64'd0);
    check("rst_lo", 64'(o_lo), 64'd0);
    check("rst_flags", {61'd0, o_busy, o_done, o_div_by_zero}, 64'd0);
    @(negedge i_clock);
    i_reset = 1'b0;

    // back-to-back: each run_op asserts its start during the previous done cycle
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
    run_op(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    run_op(2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33);
    run_op(2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 0);
    run_op(2'b10, 32'hFFFFFFFC, 32'd0,        32'hFFFFFFFC, 32'hFFFFFFFF, 1'b1, 0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33);
    run_op(2'b01, 32'h12345678, 32'h10,       32'd1,        32'h23456780, 1'b0, 33);
    run_op(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33);
    run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33);

    // stall while busy; second start (a div-by-zero) must be ignored
    @(posedge i_clock); #1;
    e.hi = 32'd0; e.lo = 32'd15; e.dbz = 1'b0;
    sb.push_back(e);
    i_start = 1'b1; i_op = 2'b01; i_a = 32'd3; i_b = 32'd5;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    i_mf = 1'b1; i_start = 1'b1; i_op = 2'b11; i_a = 32'd9; i_b = 32'd0;
    @(negedge i_clock);
    check("stall_busy_req", 64'(o_stall), 64'd1);
    @(posedge i_clock); #1;
    i_mf = 1'b0; i_start = 1'b0;
    @(negedge i_clock);
    check("stall_busy_noreq", 64'(o_stall), 64'd0);
    wait_done(bc, seen);
    check("stall_done_seen", 64'(seen), 64'd1);
    @(posedge i_clock); #1;
    i_mf = 1'b1;
    @(negedge i_clock);
    check("stall_idle", 64'(o_stall), 64'd0);
    i_mf = 1'b0;

    // MT writes, and i_valid gating
    mt(1'b1, 32'h1234);
    mt(1'b0, 32'h1234);
    check("mthi", 64'(o_hi), 64'h1234);
    check("mtlo", 64'(o_lo), 64'h1234);
    i_valid = 1'b0; i_mtlo = 1'b1; i_a = 32'hDEAD;
    @(posedge i_clock); #1;
    i_mtlo = 1'b0; i_valid = 1'b1;
    check("mtlo_invalid", 64'(o_lo), 64'h1234);

    // flush after 10 RUN cycles
    i_start = 1'b1; i_op = 2'b00; i_a = 32'd3; i_b = 32'd3;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clock);
    #1;
    i_flush = 1'b1;
    @(posedge i_clock); #1;
    i_flush = 1'b0;
    check("flush_busy", 64'(o_busy), 64'd0);
    repeat (40) @(posedge i_clock);
    #1;
    check("flush_hilo", {o_hi, o_lo}, {32'h1234, 32'h1234});

    // flush in IDLE beats start
    i_start = 1'b1; i_flush = 1'b1; i_op = 2'b01; i_a = 32'd2; i_b = 32'd2;
    @(posedge i_clock); #1;
    i_start = 1'b0; i_flush = 1'b0;
    check("idle_flush_busy", 64'(o_busy), 64'd0);

    // asynchronous reset mid-RUN
    i_start = 1'b1; i_op = 2'b01; i_a = 32'd9; i_b = 32'd9;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    repeat (5) @(posedge i_clock);
    #2;
    i_reset = 1'b1;
    #1;
    check("async_rst_hilo", {o_hi, o_lo}, 64'd0);
    check("async_rst_flags", {61'd0, o_busy, o_done, o_div_by_zero}, 64'd0);
    #1;
    i_reset = 1'b0;
    mt(1'b0, 32'hA5);
    check("post_rst_mtlo", 64'(o_lo), 64'hA5);
    check("post_rst_hi", 64'(o_hi), 64'd0);
    repeat (40) @(posedge i_clock);
    #1;
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
